// File: rtl/instr_fetch_ctrl.sv
// RISC16 fetch sequencer: owns the fetch PC, captures ROM data into a 2-entry queue,
// and hands {pc, instr} to decode over valid/ready. Optional bound check: FETCH_BOUND_CHECK_EN.
module instr_fetch_ctrl #(
   parameter int              PC_W      = 16,
   parameter int              INSTR_W   = 16,
   parameter int              ROM_WORDS = 16,
   parameter logic [PC_W-1:0] RESET_PC  = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               fetch_en,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               redir_valid,
   input  logic [PC_W-1:0]    redir_pc,
   output logic               out_valid,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc,
   input  logic               out_ready,
   output logic               fault
);

   typedef enum logic {RUN, FAULT} state_t;

   localparam logic [PC_W:0] BOUND = (PC_W+1)'(2 * ROM_WORDS);

   state_t             state_q, state_d;
   logic [PC_W-1:0]    fpc_q;
   logic [1:0]         count_q, count_d;
   logic [PC_W-1:0]    q_pc    [2];
   logic [INSTR_W-1:0] q_instr [2];

   logic pop, push_slot, in_range, push, wr_idx;

`ifdef FETCH_BOUND_CHECK_EN
   assign in_range = {1'b0, fpc_q} < BOUND;
   assign fault    = (state_q == FAULT);
`else
   // Without the check, high addresses simply alias inside the ROM.
   logic unused_bound;
   assign unused_bound = ^BOUND;
   assign in_range     = 1'b1;
   assign fault        = 1'b0;
`endif

   assign imem_addr = fpc_q;
   assign out_valid = (count_q != 2'd0);
   assign out_pc    = q_pc[0];
   assign out_instr = q_instr[0];

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      state_d   = state_q;
      count_d   = count_q;
      pop       = out_valid && out_ready;
      push_slot = fetch_en && (state_q == RUN) && (count_q < 2'd2 || pop) && !redir_valid;
      push      = push_slot && in_range;
      wr_idx    = (count_q == 2'd2) || (count_q == 2'd1 && !pop);

      if (redir_valid) begin
         state_d = RUN;
         count_d = 2'd0;
      end else begin
         if (push_slot && !in_range) state_d = FAULT;
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         fpc_q   <= RESET_PC;
         count_q <= 2'd0;
         // NOTE: the queue is only two entries and its head is visible on the ports, so it is reset too.
         for (int i = 0; i < 2; i++) begin
            q_pc[i]    <= '0;
            q_instr[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         if (redir_valid) begin
            fpc_q <= {redir_pc[PC_W-1:1], 1'b0};
         end else begin
            if (pop && count_q == 2'd2) begin
               q_pc[0]    <= q_pc[1];
               q_instr[0] <= q_instr[1];
            end
            // The head register is left alone when the queue empties, so outputs hold.
            if (push) begin
               q_pc[wr_idx]    <= fpc_q;
               q_instr[wr_idx] <= imem_data;
               fpc_q           <= fpc_q + PC_W'(2);
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Randomized self-checking bench for instr_fetch_ctrl against a queue-based reference model.
module tb_instr_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, fetch_en, redir_valid, out_ready;
   logic [15:0] redir_pc, imem_addr, imem_data, out_instr, out_pc;
   logic        out_valid, fault;

   instr_fetch_ctrl dut (
      .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .redir_valid(redir_valid), .redir_pc(redir_pc),
      .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
      .out_ready(out_ready), .fault(fault)
   );

   always #5 clk = ~clk;

   // ROM word n holds 16'h1000+n; the 16-word ROM ignores upper address bits.
   function automatic logic [15:0] rom_word(input logic [15:0] a);
      return 16'h1000 + ((a >> 1) % 16'd16);
   endfunction

   assign imem_data = rom_word(imem_addr);

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] instr;
   } ent_t;

   ent_t        mq[$];
   ent_t        m_last;
   logic [15:0] m_fpc;
   logic        m_fault;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_last  = '0;
      m_fpc   = 16'h0000;
      m_fault = 1'b0;
   endtask

   // Apply one clock edge's worth of behaviour using the inputs currently driven.
   task automatic model_edge();
      int  old_n;
      bit  pop;
      old_n = mq.size();
      pop   = (old_n > 0) && out_ready;
      if (redir_valid) begin
         mq.delete();
         m_fpc   = redir_pc & 16'hFFFE;
         m_fault = 1'b0;
      end else begin
         if (pop) void'(mq.pop_front());
         if (fetch_en && !m_fault && (old_n < 2 || pop)) begin
`ifdef FETCH_BOUND_CHECK_EN
            if (m_fpc >= 16'd32) m_fault = 1'b1;
            else begin
               mq.push_back('{pc: m_fpc, instr: rom_word(m_fpc)});
               m_fpc = m_fpc + 16'd2;
            end
`else
            mq.push_back('{pc: m_fpc, instr: rom_word(m_fpc)});
            m_fpc = m_fpc + 16'd2;
`endif
         end
      end
      if (mq.size() > 0) m_last = mq[0];
   endtask

   task automatic compare();
      check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      check("imem_addr", 32'(imem_addr), 32'(m_fpc));
      check("fault",     32'(fault),     32'(m_fault));
      check("out_pc",    32'(out_pc),    32'(m_last.pc));
      check("out_instr", 32'(out_instr), 32'(m_last.instr));
   endtask

   task automatic drive(input logic fe, input logic rv, input logic [15:0] rpc, input logic rdy);
      fetch_en    = fe;
      redir_valid = rv;
      redir_pc    = rpc;
      out_ready   = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   task automatic step(input logic fe, input logic rv, input logic [15:0] rpc, input logic rdy);
      @(negedge clk);
      drive(fe, rv, rpc, rdy);
      tick();
   endtask

   task automatic do_reset(input logic rdy);
      @(negedge clk);
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 16'h0, rdy);
      model_reset();
      #2;
      compare();
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 16'h0, rdy);
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 16'h0, 1'b0);
      model_reset();
      #12;
      compare();

      // Streaming with out_ready held high: no bubbles.
      do_reset(1'b1);
      check("first_pc", 32'(out_pc), 32'h0);
      check("first_instr", 32'(out_instr), 32'h1000);
      step(1, 0, 0, 1);
      check("stream_pc2", 32'(out_pc), 32'h2);
      step(1, 0, 0, 1);
      check("stream_instr4", 32'(out_instr), 32'h1002);

      // Back-pressure: queue fills, fetch PC holds.
      do_reset(1'b0);
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
      check("stall_addr", 32'(imem_addr), 32'h4);
      check("stall_head", 32'(out_pc), 32'h0);
      step(1, 0, 0, 1);
      check("resume_pc2", 32'(out_pc), 32'h2);
      step(1, 0, 0, 1);
      check("resume_pc4", 32'(out_pc), 32'h4);

      // Redirect while full and popping; odd target is forced even.
      step(1, 0, 0, 0);
      step(1, 1, 16'h0009, 1);
      check("redir_valid_low", 32'(out_valid), 32'h0);
      check("redir_addr", 32'(imem_addr), 32'h8);
      step(1, 0, 0, 1);
      check("redir_head", {out_pc, out_instr}, {16'h0008, 16'h1004});

      // Redirect to the top of the address space.
      step(1, 1, 16'hFFFE, 1);
      step(1, 0, 0, 1);
      step(1, 0, 0, 1);
      step(1, 0, 0, 1);
`ifndef FETCH_BOUND_CHECK_EN
      check("wrap_pc", 32'(out_pc), 32'h0002);
`endif

`ifdef FETCH_BOUND_CHECK_EN
      // Run off the end of the ROM, then recover with a redirect.
      step(1, 1, 16'd28, 1);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 1);
      check("bound_fault", 32'(fault), 32'h1);
      step(1, 1, 16'd0, 1);
      step(1, 0, 0, 1);
      check("bound_recover", {out_pc, out_instr}, {16'h0000, 16'h1000});
`endif

      // Redirect while fetch is disabled.
      step(0, 1, 16'h0010, 1);
      step(0, 0, 0, 1);
      step(1, 0, 0, 1);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         logic [15:0] rpc;
         rpc = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
         step(logic'($urandom_range(0, 9) != 0), logic'($urandom_range(0, 19) == 0),
              rpc, logic'($urandom_range(0, 9) < 7));
      end

      // Asynchronous reset with a full queue.
      step(1, 1, 16'h0006, 0);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      check("pre_reset_full", 32'(out_valid), 32'h1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_valid", 32'(out_valid), 32'h0);
      check("async_addr",  32'(imem_addr), 32'h0);
      check("async_fault", 32'(fault), 32'h0);
      model_reset();
      compare();
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 16'h0, 1'b1);
      tick();
      for (int i = 0; i < 20; i++) step(1, 0, 0, logic'($urandom_range(0, 1)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Fetch sequencer for the RISC16 instruction memory. Owns the fetch PC, drives the instruction ROM address, and captures the combinational ROM output into a 2-entry instruction queue. It hands instructions to decode over a valid/ready handshake and accepts branch/jump redirects from the datapath. It sits between the instruction memory and the control/datapath units.

## Interface
Parameters:
- `PC_W`, 16, width of PC and ROM address.
- `INSTR_W`, 16, instruction width; matches memory column width.
- `ROM_WORDS`, 16, number of instruction words in ROM; used only by the bound check.
- `RESET_PC`, 16'h0000, fetch PC after reset; must be even.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `fetch_en`  in  1  allows new fetches; the queue still drains when low.
- `imem_addr`  out  PC_W  byte address to the ROM; always equals the fetch PC register.
- `imem_data`  in  INSTR_W  ROM read data, combinational from `imem_addr`.
- `redir_valid`  in  1  redirect request, single-cycle pulse or level.
- `redir_pc`  in  PC_W  redirect target; bit 0 is forced to 0.
- `out_valid`  out  1  queue head is valid.
- `out_instr`  out  INSTR_W  queue head instruction.
- `out_pc`  out  PC_W  PC of the queue head.
- `out_ready`  in  1  decode accepts the head this cycle.
- `fault`  out  1  sticky out-of-range fetch flag.

## Operation
- Queue: 2 entries of {pc, instr}, FIFO order, with a 2-bit count of 0..2.
- Outputs come from the head entry. When count==0, `out_instr` and `out_pc` hold their last values.
- Pop: `out_valid && out_ready`.
- Push condition: `fetch_en && !fault && (count<2 || pop)`. Push writes {fpc, imem_data} and sets fpc <= fpc+2.
- Simultaneous push and pop at count 2: head advances, the new entry lands at the tail, and count stays 2.
- PC wrap: fpc 16'hFFFE + 2 gives 16'h0000. Carry is discarded and no flag is raised.
- Redirect has priority over everything:
  - Queue is flushed (count <= 0).
  - fpc <= {redir_pc[PC_W-1:1], 1'b0}.
  - No push occurs that cycle.
  - A concurrent pop is still considered accepted by decode, but its entry is discarded with the flush.
- Redirect while `fetch_en` is low: fpc is updated, the queue is flushed, and fetching resumes at the new PC when `fetch_en` rises.
- States:
  - RUN: normal operation.
  - FAULT: entered only when the bound check is compiled in. In FAULT, pushes are blocked and the queue drains normally.
  - Transitions: RUN -> FAULT on an out-of-range push attempt. FAULT -> RUN on redirect to any target. The fault flag is cleared on that redirect.
- Reset mid-operation: asynchronous. Takes effect immediately, regardless of queue contents.

## Timing
- Reset values:
  - fpc = `imem_addr` = RESET_PC
  - count = 0, `out_valid` = 0
  - `out_instr` = 0, `out_pc` = 0
  - `fault` = 0, state = RUN
- First edge after `rst_n` deasserts, with `fetch_en`=1: instruction at RESET_PC is queued, and `out_valid`=1 after that edge.
- Latency:
  - Address to queue: 1 edge.
  - Redirect edge to `out_valid` with the target instruction: 2 edges. Redirect edge loads fpc; the next edge pushes.
- Steady state with `out_ready` held 1: one instruction per cycle, with no bubbles.
- With `out_ready`=0: queue fills in 2 edges. fpc then stops advancing and `imem_addr` holds.
- `out_valid`, `out_instr` and `out_pc` are registered-state driven; there is no combinational path from `out_ready`.

## Configuration
- `FETCH_BOUND_CHECK_EN` defined:
  - A push is attempted only if fpc < 2*ROM_WORDS.
  - An attempt at or above that bound sets `fault`=1 on that edge, enters FAULT, and performs no push and no fpc increment.
- Not defined:
  - `fault` is tied to 0 and FAULT is unreachable.
  - Out-of-range addresses simply alias in the ROM (address bits above the ROM index are ignored).

## Test plan
- Reset with RESET_PC=0, ROM word n = 16'h1000+n, `out_ready`=1 -> outputs (pc 0, 16'h1000), (2, 16'h1001), (4, 16'h1002) on consecutive cycles with no bubbles.
- `out_ready`=0 for 5 cycles after reset -> count stays 2, `imem_addr`=4, head stays (0, 16'h1000). Then `out_ready`=1 -> resumes with pc 2, then pc 4, with no drop or duplicate.
- `redir_valid` pulse with `redir_pc`=16'h0009 while full and popping -> queue flushed, `imem_addr`=8, `out_valid`=0 for one cycle, then head is (8, 16'h1004).
- Redirect to 16'hFFFE with the check disabled -> pcs FFFE, 0000, 0002 in sequence.
- With `FETCH_BOUND_CHECK_EN` defined and ROM_WORDS=16, run from pc 28 -> pcs 28 and 30 are delivered, `fault`=1 at the edge fetching 32, and `out_valid` drops after the drain. A redirect to 0 then clears `fault`, and (0, 16'h1000) follows 2 edges later.
- Assert `rst_n`=0 asynchronously mid-stream with count 2 -> `out_valid`, `fault` and count go to 0 and `imem_addr` goes to RESET_PC immediately, before the next clock edge.
